freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measures the frequency of an external, asynchronous square wave, such as one of the divided 1 kHz, 100 Hz or 1 Hz clocks.
- It counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` system-clock cycles, then publishes the count as a binary result with a one-cycle valid strobe.
- It sits beside the clock divider as its self-check and as the display source for the clock's frequency-meter mode.
- Windows run back-to-back, so no input edge is lost between windows.

Parameters:
- `GATE_CYCLES`, default 12000000, gate window length in `clk` cycles (1 s at 12 MHz).
- `CNT_W`, default 24, width of the edge counter and of the result.

Ports:
- `clk`, input, 1, system clock (12 MHz).
- `rst_n`, input, 1, asynchronous active-low reset.
- `sig_in`, input, 1, signal under measurement; asynchronous to `clk`.
- `enable`, input, 1, measurement enable; level-sensitive.
- `freq`, output, `CNT_W`, edge count of the last completed window, in Hz when the gate is 1 s.
- `freq_valid`, output, 1, one-cycle pulse when `freq` updates.
- `overflow`, output, 1, the last completed window saturated the counter.
- `busy`, output, 1, a gate window is in progress.

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - `freq`=0, `freq_valid`=0, `overflow`=0, `busy`=0.
  - Synchroniser flops = 0; gate counter = 0; edge counter = 0; state = IDLE.
- Input conditioning:
  - `sig_in` passes through a 2-flop synchroniser (s1, s2), then one history flop (s3).
  - An edge is detected when s2=1 and s3=0, giving 3 cycles of latency from pin to detection.
  - High and low phases of `sig_in` must each be at least 2 `clk` periods. Shorter phases are out of spec and may be missed.
- FSM, two states, IDLE and GATE:
  - IDLE: counters held at 0, `busy`=0. When `enable`=1, go to GATE on the next cycle with gate counter = 0.
  - GATE: `busy`=1; the gate counter increments every cycle, and the edge counter increments on each detected edge.
  - Terminal cycle of GATE (gate counter = `GATE_CYCLES`-1):
    - `freq` takes edge counter + edge-this-cycle, saturated.
    - `overflow` takes the saturation flag.
    - `freq_valid`=1 for exactly this one cycle.
    - Gate counter and edge counter restart at 0 for the next window.
    - Stay in GATE if `enable`=1, else go to IDLE.
    - There is no dead cycle, so an edge on the terminal cycle belongs to the ending window.
- `enable` falling mid-window:
  - Abort and go to IDLE next cycle; counters cleared.
  - `freq` and `overflow` hold their previous values; no `freq_valid`.
- Saturation:
  - The edge counter stops at 2^`CNT_W`-1, and a sticky saturation flag is set for that window.
  - The flag clears at window restart.
- Outputs are registered. `freq` changes only on `freq_valid` cycles or at reset.
- Reset mid-window gives immediate full reset as above; the window is discarded.
- Arithmetic is unsigned.
- The gate counter width is $clog2(`GATE_CYCLES`); `GATE_CYCLES` must be at least 2.

Decomposition:
- Shared package (clock_pkg): `CLK_HZ`=12000000, the state enum {IDLE, GATE}, and `FREQ_W`=24 as the default `CNT_W`.
- Sub-module `sync_edge`: 2-flop synchroniser plus rising-edge detector (ports `clk`, `rst_n`, `async_in`, `rise`). It is reusable for the clock's push-button inputs.
- The FSM, counters and output registers stay in `freq_meter`.

Test Plan (`GATE_CYCLES`=1000, `CNT_W`=24 unless stated):
- `sig_in` period 10 `clk` (5 high/5 low), `enable`=1 continuous -> every window `freq`=100, `overflow`=0, `freq_valid` pulses exactly every 1000 cycles.
- `sig_in` held 0, then held 1 -> `freq`=0 for each window, `freq_valid` still pulses.
- `CNT_W`=4, `sig_in` period 10 -> `freq`=15, `overflow`=1. Then change the period to 100 -> next window `freq`=10, `overflow`=0.
- Windows measuring 100, then `enable` dropped at cycle 500 of the next window -> `busy`=0 within 1 cycle, no `freq_valid`, `freq` stays 100. Re-enable -> next valid `freq`=100.
- Single `sig_in` pulse timed to be detected on the terminal cycle -> counted in the ending window (`freq`=1); next window `freq`=0.
- `rst_n` pulsed low mid-window while `freq`=100 -> all outputs 0 immediately. After release with `enable`=1, the first valid arrives 1001 cycles later with `freq`=100.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and types for the clock design: system clock rate,
// default measurement width and the frequency-meter state encoding.
package clock_pkg;

    localparam int CLK_HZ = 12000000;
    localparam int FREQ_W = 24;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a one-flop
// history stage; rise pulses for one clk cycle per synchronised rising edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   hist_reg;

    assign sync_next[0] = async_in;

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // Last synchroniser stage is the "current" level, history is the previous one.
    assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and publishes a saturated result.
module freq_meter
    import clock_pkg::*;
#(
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = FREQ_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                 GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    meter_state_e      state_reg, state_next;
    logic [GATE_W-1:0] gate_cnt_reg, gate_cnt_next;
    logic [CNT_W-1:0]  edge_cnt_reg, edge_cnt_next;
    logic              sat_reg, sat_next;
    logic [CNT_W-1:0]  freq_reg, freq_next;
    logic              overflow_reg, overflow_next;
    logic              valid_reg, valid_next;

    logic              rise;
    logic [CNT_W:0]    edge_sum;
    logic              edge_carry;
    logic [CNT_W-1:0]  edge_sat;

    sync_edge #(
        .SYNC_STAGES (2)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .rise     (rise)
    );

    // One extra bit catches the step past the maximum; the count then sticks there.
    always_comb begin
        edge_sum   = {1'b0, edge_cnt_reg} + {{CNT_W{1'b0}}, rise};
        edge_carry = edge_sum[CNT_W];
        edge_sat   = edge_carry ? CNT_MAX : edge_sum[CNT_W-1:0];
    end

    always_comb begin
        state_next    = state_reg;
        gate_cnt_next = gate_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        sat_next      = sat_reg;
        freq_next     = freq_reg;
        overflow_next = overflow_reg;
        valid_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                gate_cnt_next = '0;
                edge_cnt_next = '0;
                sat_next      = 1'b0;
                if (enable) begin
                    state_next = GATE;
                end
            end

            GATE: begin
                if (gate_cnt_reg == GATE_LAST) begin
                    // Terminal cycle: an edge seen now still belongs to this window.
                    freq_next     = edge_sat;
                    overflow_next = sat_reg | edge_carry;
                    valid_next    = 1'b1;
                    gate_cnt_next = '0;
                    edge_cnt_next = '0;
                    sat_next      = 1'b0;
                    if (!enable) begin
                        state_next = IDLE;
                    end
                end else if (!enable) begin
                    state_next    = IDLE;
                    gate_cnt_next = '0;
                    edge_cnt_next = '0;
                    sat_next      = 1'b0;
                end else begin
                    gate_cnt_next = gate_cnt_reg + GATE_W'(1);
                    edge_cnt_next = edge_sat;
                    sat_next      = sat_reg | edge_carry;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            freq_reg     <= '0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gate_cnt_reg <= gate_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            sat_reg      <= sat_next;
            freq_reg     <= freq_next;
            overflow_reg <= overflow_next;
            valid_reg    <= valid_next;
        end
    end

    assign freq       = freq_reg;
    assign freq_valid = valid_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg == GATE);

endmodule
